// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and its filler LFSR.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} gen_state_t;

  localparam logic [3:0] PAT_1001  = 4'b1001;

  // x^4 + x^3 + 1: feedback is the XOR of bits 3 and 2.
  localparam logic [3:0] LFSR_SEED = 4'b1000;
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

endpackage

// File: rtl/seq_pattern_gen_lfsr4.sv
// 4-bit Fibonacci LFSR that produces filler bits for the inter-pattern gap.
// bit_o is the MSB of the current state; the state advances only on edges where en=1.
module lfsr4
  import seq_pkg::*;
(
  input  logic en,
  input  logic clk,
  input  logic rst,
  output logic bit_o
);

  logic [3:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[3];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated with optional gaps.
// Build option SEQ_GEN_GAP_NOISE_EN drives LFSR filler bits on out during gap cycles.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  gen_state_t       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gap_bit;

`ifdef SEQ_GEN_GAP_NOISE_EN
  logic noise_en;
  logic noise_bit;

  // Advance exactly on the edges that load a GAP cycle's output bit.
  assign noise_en = (state_d == GAP);

  lfsr4 u_lfsr (
    .en    (noise_en),
    .clk   (clk),
    .rst   (rst),
    .bit_o (noise_bit)
  );

  assign gap_bit = noise_bit;
`else
  assign gap_bit = 1'b0;
`endif

  // Outputs are computed for the cycle that follows the edge, so every port is a flop.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    reps_d    = reps_q;
    gap_len_d = gap_len_q;
    gap_d     = gap_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          pat_d     = pattern;
          reps_d    = repeat_cnt;
          gap_len_d = gap_len;
          busy_d    = 1'b1;
          if (repeat_cnt == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
            idx_d   = '0;
            out_d   = pattern[PAT_W-1];
            shreg_d = pattern << 1;
            valid_d = 1'b1;
          end
        end
      end

      SEND: begin
        busy_d = 1'b1;
        if (idx_q != IDX_LAST) begin
          idx_d   = idx_q + 1'b1;
          out_d   = shreg_q[PAT_W-1];
          shreg_d = shreg_q << 1;
          valid_d = 1'b1;
        end else begin
          reps_d = reps_q - 1'b1;
          if (reps_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (gap_len_q == '0) begin
            idx_d   = '0;
            out_d   = pat_q[PAT_W-1];
            shreg_d = pat_q << 1;
            valid_d = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = gap_len_q;
            out_d   = gap_bit;
          end
        end
      end

      GAP: begin
        busy_d = 1'b1;
        if (gap_q == GAP_W'(1)) begin
          state_d = SEND;
          idx_d   = '0;
          out_d   = pat_q[PAT_W-1];
          shreg_d = pat_q << 1;
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
          out_d = gap_bit;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition above, including the done pulse.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      out_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      shreg_q   <= '0;
      idx_q     <= '0;
      reps_q    <= '0;
      gap_len_q <= '0;
      gap_q     <= '0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      reps_q    <= reps_d;
      gap_len_q <= gap_len_d;
      gap_q     <= gap_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen in its default build; each cycle is checked as {out_valid,out,busy,done}.
module tb_seq_pattern_gen;
  import seq_pkg::*;

  localparam logic [3:0] S1 = 4'b1110;  // sending a 1
  localparam logic [3:0] S0 = 4'b1010;  // sending a 0
  localparam logic [3:0] G  = 4'b0010;  // gap cycle
  localparam logic [3:0] D  = 4'b0011;  // done pulse
  localparam logic [3:0] I  = 4'b0000;  // idle

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] repeat_cnt = '0;
  logic [3:0] gap_len = '0;
  logic       out, out_valid, busy, done;

  int checks = 0;
  int errors = 0;
  logic [3:0] cap [0:31];

  seq_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Presents start for exactly one edge (edge k); returns just after edge k.
  task automatic launch(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
    @(negedge clk);
    pattern = p; repeat_cnt = r; gap_len = g; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cap[i] holds the outputs of cycle k+1+i.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap[i] = {out_valid, out, busy, done};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; pattern = 4'b1111; repeat_cnt = 8'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out, busy, done} !== I) begin
      errors++; $display("FAIL reset_held got %b want %b", {out_valid, out, busy, done}, I);
    end
    start = 1'b0; rst = 1'b0;
    capture(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cap[i] !== I) begin
        errors++; $display("FAIL reset_release c%0d got %b want %b", i, cap[i], I);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_a [0:5];
    logic [3:0] exp_b [0:5];
    exp_a = '{S1, S0, S0, S1, D, I};
    exp_b = '{S1, S1, S1, S0, D, I};
    launch(PAT_1001, 8'd1, 4'd0);
    capture(6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap[i] !== exp_a[i]) begin
        errors++; $display("FAIL single_1001 c%0d got %b want %b", i, cap[i], exp_a[i]);
      end
    end
    launch(4'b1110, 8'd1, 4'd7);
    capture(6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap[i] !== exp_b[i]) begin
        errors++; $display("FAIL single_1110 c%0d got %b want %b", i, cap[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_repeat_gap();
    logic [3:0] exp_a [0:11];
    logic [3:0] exp_b [0:10];
    int dones;
    exp_a = '{S1, S0, S0, S1, G, G, S1, S0, S0, S1, D, I};
    exp_b = '{S0, S1, S0, S1, G, S0, S1, S0, S1, D, I};
    launch(PAT_1001, 8'd2, 4'd2);
    capture(12);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      dones += int'(cap[i][0]);
      checks++;
      if (cap[i] !== exp_a[i]) begin
        errors++; $display("FAIL gap2 c%0d got %b want %b", i, cap[i], exp_a[i]);
      end
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL gap2_done_count got %0d want 1", dones);
    end
    launch(4'b0101, 8'd2, 4'd1);
    capture(11);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (cap[i] !== exp_b[i]) begin
        errors++; $display("FAIL gap1 c%0d got %b want %b", i, cap[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [0:13];
    exp = '{S1, S0, S0, S1, S1, S0, S0, S1, S1, S0, S0, S1, D, I};
    launch(PAT_1001, 8'd3, 4'd0);
    capture(14);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (cap[i] !== exp[i]) begin
        errors++; $display("FAIL b2b c%0d got %b want %b", i, cap[i], exp[i]);
      end
    end
  endtask

  task automatic test_zero_and_ignored_start();
    logic [3:0] exp_z [0:2];
    logic [3:0] exp_s [0:7];
    exp_z = '{D, I, I};
    exp_s = '{S1, S0, S0, S1, D, I, I, I};
    launch(PAT_1001, 8'd0, 4'd3);
    capture(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap[i] !== exp_z[i]) begin
        errors++; $display("FAIL rep0 c%0d got %b want %b", i, cap[i], exp_z[i]);
      end
    end
    launch(PAT_1001, 8'd1, 4'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cap[i] = {out_valid, out, busy, done};
      if (i == 1) begin
        start = 1'b1; pattern = 4'b0110; repeat_cnt = 8'd5;
      end
      if (i == 2) start = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap[i] !== exp_s[i]) begin
        errors++; $display("FAIL start_busy c%0d got %b want %b", i, cap[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0] exp [0:7];
    exp = '{S1, S0, I, I, I, I, I, I};
    launch(PAT_1001, 8'd2, 4'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cap[i] = {out_valid, out, busy, done};
      if (i == 1) abort = 1'b1;
      if (i == 2) abort = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap[i] !== exp[i]) begin
        errors++; $display("FAIL abort c%0d got %b want %b", i, cap[i], exp[i]);
      end
    end
    // Start together with abort in IDLE must not be accepted.
    @(negedge clk);
    pattern = PAT_1001; repeat_cnt = 8'd1; gap_len = 4'd0; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    capture(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap[i] !== I) begin
        errors++; $display("FAIL abort_idle_start c%0d got %b want %b", i, cap[i], I);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [3:0] exp [0:9];
    logic [3:0] exp2 [0:5];
    exp  = '{S1, S0, S0, S1, G, G, I, I, I, I};
    exp2 = '{S0, S1, S1, S0, D, I};
    launch(PAT_1001, 8'd2, 4'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cap[i] = {out_valid, out, busy, done};
      if (i == 5) rst = 1'b1;
      if (i == 6) rst = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cap[i] !== exp[i]) begin
        errors++; $display("FAIL rst_gap c%0d got %b want %b", i, cap[i], exp[i]);
      end
    end
    launch(4'b0110, 8'd1, 4'd0);
    capture(6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap[i] !== exp2[i]) begin
        errors++; $display("FAIL after_rst c%0d got %b want %b", i, cap[i], exp2[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat_gap();
    test_back_to_back();
    test_zero_and_ignored_start();
    test_abort();
    test_reset_mid_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
